// File: rtl/fc_stream_layer_pkg.sv
// Shared definitions for the streaming fully-connected layers.
// Holds the layer FSM state encoding and Q-format saturating arithmetic helpers.
// The helpers work on values sign-extended to QMaxW bits. The caller passes the
// real data width w and the fractional bit count, so one package serves layers
// of any DATA_W up to QMaxW.
package fc_stream_layer_pkg;

  typedef enum logic [1:0] {
    StRec  = 2'd0,
    StMac  = 2'd1,
    StSend = 2'd2
  } fc_state_e;

  localparam int unsigned QMaxW = 64;

  typedef logic signed [QMaxW-1:0]   q_word_t;
  typedef logic signed [2*QMaxW-1:0] q_wide_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic q_word_t q_sat(input q_wide_t x, input int unsigned w);
    q_wide_t max_v;
    q_wide_t min_v;
    max_v = (q_wide_t'(1) <<< (w - 1)) - q_wide_t'(1);
    min_v = -max_v - q_wide_t'(1);
    if (x > max_v) begin
      return max_v[QMaxW-1:0];
    end else if (x < min_v) begin
      return min_v[QMaxW-1:0];
    end
    return x[QMaxW-1:0];
  endfunction

  // Full-precision product, rescaled by the Q fraction, then saturated to w bits.
  function automatic q_word_t q_sat_mul(input q_word_t a, input q_word_t b,
                                        input int unsigned w, input int unsigned frac);
    q_wide_t p;
    p = q_wide_t'(a) * q_wide_t'(b);
    return q_sat(p >>> frac, w);
  endfunction

  function automatic q_word_t q_sat_add(input q_word_t a, input q_word_t b,
                                        input int unsigned w);
    return q_sat(q_wide_t'(a) + q_wide_t'(b), w);
  endfunction

endpackage

// File: rtl/fc_stream_layer_q_sat_mac.sv
// Combinational saturating Q-format multiply-accumulate: sum_o = sat(acc_i + sat(x_i*w_i)).
// Ports: acc_i running sum, x_i activation, w_i weight, sum_o new sum (all DATA_W, signed).
module q_sat_mac
  import fc_stream_layer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FRAC_W = 15
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] w_i,
  output logic [DATA_W-1:0] sum_o
);

  q_word_t acc_x, x_x, w_x, prod, sum;

  always_comb begin
    acc_x = q_word_t'(signed'(acc_i));
    x_x   = q_word_t'(signed'(x_i));
    w_x   = q_word_t'(signed'(w_i));
    prod  = q_sat_mul(x_x, w_x, DATA_W, FRAC_W);
    sum   = q_sat_add(acc_x, prod, DATA_W);
    sum_o = sum[DATA_W-1:0];
  end

endmodule

// File: rtl/fc_stream_layer.sv
// Streaming fully-connected layer with an external synchronous weight RAM.
// Ports: clk/rst (async, active high); load_weights selects weight-load mode;
// in_valid/in_rdy/in_data/in_idx/in_idx2 is the input stream; out_valid/out_rdy/
// out_data/out_idx/out_last is the result stream; wt_we/wt_addr/wt_wdata/wt_rdata
// drive the weight RAM (address = {input index, output index}, 1-cycle read latency).
module fc_stream_layer
  import fc_stream_layer_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned FRAC_W   = 15,
  parameter int unsigned N_IN     = 1024,
  parameter int unsigned N_OUT    = 10,
  parameter int unsigned IN_AW    = 10,
  parameter int unsigned OUT_AW   = 4,
  parameter int unsigned ACT_RELU = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_weights,
  input  logic                    in_valid,
  output logic                    in_rdy,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [IN_AW-1:0]        in_idx,
  input  logic [OUT_AW-1:0]       in_idx2,
  output logic                    out_valid,
  input  logic                    out_rdy,
  output logic [DATA_W-1:0]       out_data,
  output logic [OUT_AW-1:0]       out_idx,
  output logic                    out_last,
  output logic                    wt_we,
  output logic [IN_AW+OUT_AW-1:0] wt_addr,
  output logic [DATA_W-1:0]       wt_wdata,
  input  logic [DATA_W-1:0]       wt_rdata
);

  localparam int unsigned CntW = $clog2(N_IN + 1);
  localparam int unsigned IdxW = IN_AW + 1;
  localparam int unsigned MacW = OUT_AW + 1;

  fc_state_e                state_q, state_d;
  logic [CntW-1:0]          count_q, count_d;
  logic [IN_AW-1:0]         idx_q, idx_d;
  logic [DATA_W-1:0]        x_q, x_d;
  logic [MacW-1:0]          mac_cnt_q, mac_cnt_d;
  logic [OUT_AW-1:0]        k_q, k_d;
  logic [DATA_W-1:0]        acc_q [N_OUT];
  logic [DATA_W-1:0]        acc_d [N_OUT];
  logic                     wt_we_q, wt_we_d;
  logic [IN_AW+OUT_AW-1:0]  wt_addr_q, wt_addr_d;
  logic [DATA_W-1:0]        wt_wdata_q, wt_wdata_d;

  logic              in_xfer, out_xfer, accept, mac_done, last_in, last_beat;
  logic [MacW-1:0]   next_o;
  logic [DATA_W-1:0] acc_mac, mac_sum, acc_k;

  assign in_xfer   = in_valid & in_rdy;
  assign out_xfer  = out_valid & out_rdy;
  // Out-of-range indices are consumed but never start a MAC pass.
  assign accept    = in_xfer & ~load_weights & ({1'b0, in_idx} < IdxW'(N_IN));
  assign mac_done  = (state_q == StMac) && (mac_cnt_q == MacW'(N_OUT));
  assign last_in   = count_q == CntW'(N_IN - 1);
  assign last_beat = k_q == OUT_AW'(N_OUT - 1);
  assign next_o    = mac_cnt_q + MacW'(1);

  // MAC cycle c consumes the RAM word addressed in cycle c-1, i.e. weight column c-1.
  always_comb begin
    acc_mac = '0;
    acc_k   = '0;
    for (int o = 0; o < N_OUT; o++) begin
      if (mac_cnt_q == MacW'(o + 1)) acc_mac = acc_q[o];
      if (k_q == OUT_AW'(o)) acc_k = acc_q[o];
    end
  end

  q_sat_mac #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_mac (
    .acc_i (acc_mac),
    .x_i   (x_q),
    .w_i   (wt_rdata),
    .sum_o (mac_sum)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StRec;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRec:   if (accept) state_d = StMac;
      StMac:   if (mac_done) state_d = last_in ? StSend : StRec;
      StSend:  if (out_xfer && last_beat) state_d = StRec;
      default: state_d = StRec;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_rdy    = (state_q == StRec);
    out_valid = (state_q == StSend);
    out_idx   = out_valid ? k_q : '0;
    out_last  = out_valid & last_beat;
    out_data  = '0;
    if (out_valid) begin
      out_data = ((ACT_RELU != 0) && acc_k[DATA_W-1]) ? '0 : acc_k;
    end
    wt_we    = wt_we_q;
    wt_addr  = wt_addr_q;
    wt_wdata = wt_wdata_q;
  end

  // Datapath next state
  always_comb begin
    count_d    = count_q;
    idx_d      = idx_q;
    x_d        = x_q;
    mac_cnt_d  = mac_cnt_q;
    k_d        = k_q;
    acc_d      = acc_q;
    wt_we_d    = 1'b0;
    wt_addr_d  = wt_addr_q;
    wt_wdata_d = wt_wdata_q;
    unique case (state_q)
      StRec: begin
        if (in_xfer && load_weights) begin
          wt_we_d    = 1'b1;
          wt_addr_d  = {in_idx, in_idx2};
          wt_wdata_d = in_data;
        end else if (accept) begin
          idx_d     = in_idx;
          x_d       = in_data;
          mac_cnt_d = '0;
          wt_addr_d = {in_idx, OUT_AW'(0)};
        end
      end
      StMac: begin
        mac_cnt_d = next_o;
        if (next_o < MacW'(N_OUT)) wt_addr_d = {idx_q, next_o[OUT_AW-1:0]};
        for (int o = 0; o < N_OUT; o++) begin
          if (mac_cnt_q == MacW'(o + 1)) acc_d[o] = mac_sum;
        end
        if (mac_done) begin
          count_d = count_q + CntW'(1);
          k_d     = '0;
        end
      end
      StSend: begin
        if (out_xfer) begin
          if (last_beat) begin
            for (int o = 0; o < N_OUT; o++) acc_d[o] = '0;
            count_d = '0;
            k_d     = '0;
          end else begin
            k_d = k_q + OUT_AW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      idx_q      <= '0;
      x_q        <= '0;
      mac_cnt_q  <= '0;
      k_q        <= '0;
      for (int o = 0; o < N_OUT; o++) acc_q[o] <= '0;
      wt_we_q    <= 1'b0;
      wt_addr_q  <= '0;
      wt_wdata_q <= '0;
    end else begin
      count_q    <= count_d;
      idx_q      <= idx_d;
      x_q        <= x_d;
      mac_cnt_q  <= mac_cnt_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      wt_we_q    <= wt_we_d;
      wt_addr_q  <= wt_addr_d;
      wt_wdata_q <= wt_wdata_d;
    end
  end

endmodule

// File: tb/tb_fc_stream_layer.sv
// Directed bench for fc_stream_layer (N_IN=4, N_OUT=3, Q17.15). Two instances share
// the input stream: u_relu (ACT_RELU=1) and u_lin (ACT_RELU=0), each with its own RAM.
module tb_fc_stream_layer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_IN   = 4;
  localparam int unsigned N_OUT  = 3;
  localparam int unsigned IN_AW  = 3;
  localparam int unsigned OUT_AW = 2;
  localparam int unsigned AW     = IN_AW + OUT_AW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_weights = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_rdy = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [IN_AW-1:0]  in_idx = '0;
  logic [OUT_AW-1:0] in_idx2 = '0;

  logic              in_rdy0, in_rdy1, out_valid0, out_valid1, out_last0, out_last1;
  logic              wt_we0, wt_we1;
  logic [DATA_W-1:0] out_data0, out_data1, wt_wdata0, wt_wdata1, wt_rdata0, wt_rdata1;
  logic [OUT_AW-1:0] out_idx0, out_idx1;
  logic [AW-1:0]     wt_addr0, wt_addr1;
  logic [DATA_W-1:0] mem0 [2**AW];
  logic [DATA_W-1:0] mem1 [2**AW];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clk = ~clk;

  fc_stream_layer #(
    .DATA_W(DATA_W), .FRAC_W(15), .N_IN(N_IN), .N_OUT(N_OUT),
    .IN_AW(IN_AW), .OUT_AW(OUT_AW), .ACT_RELU(1)
  ) u_relu (
    .clk(clk), .rst(rst), .load_weights(load_weights), .in_valid(in_valid),
    .in_rdy(in_rdy0), .in_data(in_data), .in_idx(in_idx), .in_idx2(in_idx2),
    .out_valid(out_valid0), .out_rdy(out_rdy), .out_data(out_data0),
    .out_idx(out_idx0), .out_last(out_last0), .wt_we(wt_we0), .wt_addr(wt_addr0),
    .wt_wdata(wt_wdata0), .wt_rdata(wt_rdata0)
  );

  fc_stream_layer #(
    .DATA_W(DATA_W), .FRAC_W(15), .N_IN(N_IN), .N_OUT(N_OUT),
    .IN_AW(IN_AW), .OUT_AW(OUT_AW), .ACT_RELU(0)
  ) u_lin (
    .clk(clk), .rst(rst), .load_weights(load_weights), .in_valid(in_valid),
    .in_rdy(in_rdy1), .in_data(in_data), .in_idx(in_idx), .in_idx2(in_idx2),
    .out_valid(out_valid1), .out_rdy(out_rdy), .out_data(out_data1),
    .out_idx(out_idx1), .out_last(out_last1), .wt_we(wt_we1), .wt_addr(wt_addr1),
    .wt_wdata(wt_wdata1), .wt_rdata(wt_rdata1)
  );

  // Synchronous-read weight RAMs, one cycle of read latency.
  always @(posedge clk) begin
    if (wt_we0) mem0[wt_addr0] <= wt_wdata0;
    if (wt_we1) mem1[wt_addr1] <= wt_wdata1;
    wt_rdata0 <= mem0[wt_addr0];
    wt_rdata1 <= mem1[wt_addr1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy();
    int t = 0;
    while (!in_rdy0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_rdy0) chk("in_rdy timeout", {31'b0, in_rdy0}, 32'd1);
  endtask

  task automatic load_w(input int row, input int col, input logic [31:0] val);
    wait_rdy();
    load_weights = 1'b1;
    in_valid     = 1'b1;
    in_idx       = IN_AW'(row);
    in_idx2      = OUT_AW'(col);
    in_data      = val;
    @(negedge clk);
    in_valid     = 1'b0;
    load_weights = 1'b0;
  endtask

  // Column c gets base*(c+1) when scale is set, otherwise every weight is base.
  task automatic load_all(input logic [31:0] base, input bit scale);
    for (int r = 0; r < N_IN; r++) begin
      for (int c = 0; c < N_OUT; c++) begin
        load_w(r, c, scale ? base * 32'(c + 1) : base);
      end
    end
  endtask

  // Returns the number of cycles in_rdy stayed low after the transfer.
  task automatic send_in(input int idx, input logic [31:0] val, output int mac_cycles);
    wait_rdy();
    in_valid = 1'b1;
    in_idx   = IN_AW'(idx);
    in_data  = val;
    @(negedge clk);
    in_valid   = 1'b0;
    mac_cycles = 0;
    while (!in_rdy0 && !out_valid0 && mac_cycles < 20) begin
      mac_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic get_beat(input string tag, input logic [31:0] exp0, input logic [31:0] exp1,
                          input int idx, input bit last);
    int t = 0;
    while (!out_valid0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " valid"}, {31'b0, out_valid0}, 32'd1);
    chk({tag, " data relu"}, out_data0, exp0);
    chk({tag, " data lin"}, out_data1, exp1);
    chk({tag, " idx"}, {30'b0, out_idx0}, 32'(idx));
    chk({tag, " last"}, {31'b0, out_last0}, {31'b0, last});
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    if (last) begin
      chk({tag, " valid drop"}, {31'b0, out_valid0}, 32'd0);
      chk({tag, " back to rec"}, {31'b0, in_rdy0}, 32'd1);
    end
  endtask

  task automatic frame_ones();
    for (int i = 0; i < N_IN; i++) send_in(i, 32'h0000_8000, cyc);
  endtask

  initial begin
    for (int a = 0; a < 2**AW; a++) begin
      mem0[a] = '0;
      mem1[a] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst in_rdy", {31'b0, in_rdy0}, 32'd1);
    chk("rst out_valid", {31'b0, out_valid0}, 32'd0);
    chk("rst out_data", out_data0, 32'd0);
    chk("rst out_idx", {30'b0, out_idx0}, 32'd0);
    chk("rst out_last", {31'b0, out_last0}, 32'd0);
    chk("rst wt_we", {31'b0, wt_we0}, 32'd0);
    chk("rst wt_addr", {27'b0, wt_addr0}, 32'd0);
    chk("rst wt_wdata", wt_wdata0, 32'd0);

    // Single load write: one-cycle pulse with {row, col} address
    load_w(1, 2, 32'h0000_8000);
    chk("load we", {31'b0, wt_we0}, 32'd1);
    chk("load addr", {27'b0, wt_addr0}, 32'd6);
    chk("load wdata", wt_wdata0, 32'h0000_8000);
    @(negedge clk);
    chk("load we pulse", {31'b0, wt_we0}, 32'd0);

    // Unity weights and inputs; an out-of-range index is swallowed without a MAC
    load_all(32'h0000_8000, 1'b0);
    send_in(0, 32'h0000_8000, cyc);
    chk("mac length", 32'(cyc), 32'd4);
    send_in(5, 32'h1234_5678, cyc);
    chk("discard no mac", 32'(cyc), 32'd0);
    for (int i = 1; i < N_IN; i++) send_in(i, 32'h0000_8000, cyc);
    get_beat("unity b0", 32'h0002_0000, 32'h0002_0000, 0, 1'b0);
    get_beat("unity b1", 32'h0002_0000, 32'h0002_0000, 1, 1'b0);
    get_beat("unity b2", 32'h0002_0000, 32'h0002_0000, 2, 1'b1);

    // Negative weights: ReLU clamps to 0, identity passes -4.0
    load_all(32'hFFFF_8000, 1'b0);
    frame_ones();
    for (int k = 0; k < N_OUT; k++) begin
      get_beat("neg", 32'h0, 32'hFFFE_0000, k, k == N_OUT - 1);
    end

    // Per-column weights, duplicate index, back-pressure on beat 1
    load_all(32'h0000_8000, 1'b1);
    send_in(0, 32'h0000_8000, cyc);
    send_in(0, 32'h0000_8000, cyc);
    send_in(1, 32'h0000_8000, cyc);
    send_in(2, 32'h0000_8000, cyc);
    get_beat("bp b0", 32'h0002_0000, 32'h0002_0000, 0, 1'b0);
    for (int s = 0; s < 5; s++) begin
      chk("bp hold valid", {31'b0, out_valid0}, 32'd1);
      chk("bp hold data", out_data0, 32'h0004_0000);
      chk("bp hold idx", {30'b0, out_idx0}, 32'd1);
      @(negedge clk);
    end
    get_beat("bp b1", 32'h0004_0000, 32'h0004_0000, 1, 1'b0);
    get_beat("bp b2", 32'h0006_0000, 32'h0006_0000, 2, 1'b1);

    // Saturation of both the product and the running sum
    load_all(32'h7FFF_FFFF, 1'b0);
    for (int i = 0; i < N_IN; i++) send_in(i, 32'h7FFF_FFFF, cyc);
    for (int k = 0; k < N_OUT; k++) begin
      get_beat("sat", 32'h7FFF_FFFF, 32'h7FFF_FFFF, k, k == N_OUT - 1);
    end

    // Reset in the middle of the MAC for input 2, then a clean frame
    load_all(32'h0000_8000, 1'b0);
    send_in(0, 32'h0000_8000, cyc);
    send_in(1, 32'h0000_8000, cyc);
    wait_rdy();
    in_valid = 1'b1;
    in_idx   = 3'd2;
    in_data  = 32'h0000_8000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid mac busy", {31'b0, in_rdy0}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst valid", {31'b0, out_valid0}, 32'd0);
    chk("mid rst rdy", {31'b0, in_rdy0}, 32'd1);
    for (int o = 0; o < N_OUT; o++) chk("mid rst acc", u_relu.acc_q[o], 32'd0);
    repeat (6) @(negedge clk);
    chk("mid rst no beat", {31'b0, out_valid0}, 32'd0);
    frame_ones();
    for (int k = 0; k < N_OUT; k++) begin
      get_beat("fresh", 32'h0002_0000, 32'h0002_0000, k, k == N_OUT - 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fc_stream_layer.md
FC_STREAM_LAYER -- requirements
Module: fc_stream_layer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, two's-complement data/weight width.
REQ-002 SHALL have parameter FRAC_W, default 15, fractional bits (Q format).
REQ-003 SHALL have parameter N_IN, default 1024, inputs per frame.
REQ-004 SHALL have parameter N_OUT, default 10, output neurons (N_OUT <= 2**OUT_AW).
REQ-005 SHALL have parameters IN_AW, default 10, and OUT_AW, default 4, address widths.
REQ-006 SHALL have parameter ACT_RELU, default 1; 1 = ReLU on output, 0 = identity.
REQ-007 clk  in  1  single clock; all state changes on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 load_weights  in  1  weight-load mode select.
REQ-010 in_valid / in_rdy  in / out  1 / 1  input handshake; transfer when both high.
REQ-011 in_data  in  DATA_W  activation value, or weight value in load mode.
REQ-012 in_idx  in  IN_AW  input index (load mode: input row of weight).
REQ-013 in_idx2  in  OUT_AW  output column of weight; used in load mode only.
REQ-014 out_valid / out_rdy  out / in  1 / 1  output handshake.
REQ-015 out_data  out  DATA_W, out_idx  out  OUT_AW, out_last  out  1  result, its neuron index, final-beat flag.
REQ-016 wt_we  out  1, wt_addr  out  IN_AW+OUT_AW, wt_wdata  out  DATA_W, wt_rdata  in  DATA_W  external weight RAM, synchronous read, 1-cycle latency.

Function
REQ-017 SHALL implement states REC, MAC, SEND; weight address = {input index, output index}.
REQ-018 REC: in_rdy=1; load_weights=1 with transfer SHALL drive wt_we=1, wt_addr={in_idx,in_idx2}, wt_wdata=in_data on next cycle, pulse one cycle per transfer.
REQ-019 REC: load_weights=0 with transfer and in_idx < N_IN SHALL latch in_data, go to MAC; in_idx >= N_IN SHALL be accepted and discarded, not counted.
REQ-020 MAC: in_rdy=0; SHALL issue wt_addr={idx,o} for o=0..N_OUT-1 on consecutive cycles and update acc[o] one cycle later; MAC lasts exactly N_OUT+1 cycles.
REQ-021 Product SHALL be full 2*DATA_W signed, arithmetic-shifted right FRAC_W, saturated to DATA_W; sum acc[o]+product SHALL saturate to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
REQ-022 After MAC, SHALL increment accepted-input count; count < N_IN -> REC, count == N_IN -> SEND.
REQ-023 SEND: out_valid=1, out_data=act(acc[k]), out_idx=k, out_last=(k==N_OUT-1); outputs SHALL hold stable until out_rdy.
REQ-024 act(x) SHALL be 0 for x<0 when ACT_RELU=1, x otherwise.
REQ-025 On final SEND handshake SHALL clear all acc and count to 0, out_valid=0 next cycle, return to REC.
REQ-026 load_weights asserted during MAC or SEND SHALL be ignored; wt_we SHALL be 0 outside load writes.
REQ-027 Duplicate in_idx values SHALL each be accumulated (no duplicate suppression).

Reset
REQ-028 rst SHALL force state REC, acc all 0, count 0, out_valid 0, out_data 0, out_idx 0, out_last 0, wt_we 0, wt_addr 0, wt_wdata 0, in_rdy 1 (combinational from state).
REQ-029 rst mid-MAC or mid-SEND SHALL abandon the frame; no partial output beats after reset.

Structure
REQ-030 Shared package SHALL hold state encoding and Q-format saturating multiply/add functions, reused by sibling layers.
REQ-031 Saturating multiply-accumulate SHALL be one sub-module, q_sat_mac.

Verification (N_IN=4, N_OUT=3, DATA_W=32, FRAC_W=15)
REQ-032 Load all weights 0x8000 (1.0), inputs 0x8000 x4 -> outputs 0x20000 x3, out_last on idx 2.
REQ-033 Weights -1.0 (0xFFFF8000), ACT_RELU=1, inputs 1.0 -> all outputs 0; ACT_RELU=0 -> 0xFFFE0000.
REQ-034 Weights 0x7FFFFFFF, inputs 0x7FFFFFFF -> outputs 0x7FFFFFFF (saturation, no wrap).
REQ-035 out_rdy low 5 cycles on beat 1 -> out_data/out_idx stable, no beat lost or repeated.
REQ-036 rst asserted during MAC of input 2 -> out_valid 0, acc 0; fresh 4-input frame gives correct results.
